set_assoc_icache: RTL and testbench
===================================

# set_assoc_icache

Parametrised, synchronous, read-only instruction cache between the fetch stage and instruction memory. It is N-way set-associative and uses a ready/valid request handshake instead of event-triggered lookups. Misses refill a whole line through a burst memory port, and the per-set victim choice is round-robin. It also supports a single-cycle flush for code reloads.

## Interface
- ADDR_WIDTH, 32, word address width; byte addressing is not used.
- DATA_WIDTH, 32, instruction word width.
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 4, number of sets; power of two, at least 2.
- WORDS_PER_BLOCK, 16, words per line; power of two, at least 2.
- Derived: OFF = log2(WORDS_PER_BLOCK), IDX = log2(SETS), TAG = ADDR_WIDTH - IDX - OFF. Address layout is {tag, index, offset}.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_WIDTH  word address to read.
- req_ready  out  1  cache can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; resp_data is valid.
- resp_data  out  DATA_WIDTH  instruction word for the last accepted request.
- flush  in  1  invalidate all lines.
- busy  out  1  refill in progress (states MISS_REQ, REFILL, RESPOND).
- mem_req_valid  out  1  line-fill request.
- mem_req_addr  out  ADDR_WIDTH  line base address; offset bits are 0.
- mem_req_ready  in  1  memory accepts the fill request.
- mem_resp_valid  in  1  one fill beat present.
- mem_resp_data  in  DATA_WIDTH  fill beat data.

## Operation
- Storage:
  - data array: WAYS x SETS x WORDS_PER_BLOCK words.
  - per line: tag and valid bit.
  - per set: round-robin pointer of log2(WAYS) bits.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
- IDLE:
  - req_ready = !flush && !flush_pending.
  - Flush, or a pending flush, clears every valid bit in one cycle and clears flush_pending.
  - On req_valid && req_ready, register req_addr and go to LOOKUP.
- LOOKUP:
  - Compare the tag against all ways of the indexed set. A hit requires valid && tag match.
  - Hit: resp_valid = 1 and resp_data = the word at the offset, both in this cycle; then go to IDLE.
  - Miss: go to MISS_REQ.
- Victim selection:
  - Use the lowest-numbered invalid way in the set.
  - If every way is valid, use the set's round-robin pointer.
  - The pointer increments modulo WAYS on every refill of that set, whether the victim was invalid or chosen by the pointer.
- MISS_REQ:
  - mem_req_valid = 1 and mem_req_addr = {tag, index, 0}, held stable until mem_req_ready is sampled high. Then go to REFILL with beat counter = 0.
- REFILL:
  - Each cycle with mem_resp_valid, write mem_resp_data to victim word[counter] and increment the counter.
  - Beats arrive in offset order 0..WORDS_PER_BLOCK-1. Gaps between beats are allowed.
  - On the last beat, write the tag, set valid, advance the pointer, and go to RESPOND.
  - The line is never marked valid before the last beat.
- RESPOND: resp_valid = 1, resp_data = the requested word from the new line; then go to IDLE.
- Responses cannot be stalled; fetch always consumes resp_valid.
- The cache is read-only. It has no dirty state and no write-back.
- mem_resp_valid outside REFILL is ignored.
- Flush asserted outside IDLE sets flush_pending. The in-flight request still completes and responds, and the invalidation happens on the next IDLE cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; all valid bits = 0; pointers = 0; counter = 0; flush_pending = 0.
  - req_ready = 0 while reset is high, then 1 after release.
  - resp_valid = 0, resp_data = 0, mem_req_valid = 0, mem_req_addr = 0, busy = 0.
- Reset during MISS_REQ or REFILL abandons the fill. No line becomes valid, and later beats are ignored.
- Hit: request accepted at edge k; resp_valid is high in cycle k+1; next accept is possible at edge k+2. Throughput is one hit per 2 cycles.
- Miss, with mem_req_ready high at once and beats back-to-back from cycle k+3:
  - mem_req_valid is high in cycle k+2.
  - The last beat is in cycle k+2+WORDS_PER_BLOCK.
  - resp_valid is high in cycle k+3+WORDS_PER_BLOCK.
- Flush and req_valid in the same IDLE cycle: the flush wins, and the request is accepted on a later cycle.

## Test plan
- Reset, then read 0x0000_0025 (default parameters): miss; mem_req_addr = 0x20. Feed beats 0x100..0x10F. resp_data = 0x105 at cycle k+19. A repeat read of 0x25 hits in cycle k+1 with 0x105.
- Conflict within a set, WAYS=2 (index bits [5:4]): fill 0x000 into way0 and 0x040 into way1, then read 0x080. Way0 is evicted (pointer = 0); after refill the pointer is 1. 0x040 still hits and 0x000 misses.
- Stalled memory: mem_req_ready is held low for 5 cycles; mem_req_valid and mem_req_addr stay stable. 3-cycle gaps between beats still produce the correct line, and busy stays high throughout.
- Flush mid-refill: flush pulses during REFILL. The current response is still delivered; one cycle later all valid bits are 0, and a re-read of the same address misses.
- Reset at beat 7 of a refill: outputs go to their reset values immediately. Stray beats afterwards are ignored. A read of the same address misses and refills correctly.
- Parameter sweep: WAYS=1, 4, 8 and WORDS_PER_BLOCK=2, 16 with random addresses checked against a memory model. Every response equals the model word, and the hit count matches a reference model of the round-robin policy.

Source files
------------

// File: rtl/set_assoc_icache.sv
// N-way set-associative read-only instruction cache with ready/valid fetch port,
// burst line refill, per-set round-robin replacement and single-cycle flush.
module set_assoc_icache #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WAYS            = 2,
    parameter int unsigned SETS            = 4,
    parameter int unsigned WORDS_PER_BLOCK = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  flush,
    output logic                  busy,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int unsigned OFF   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG   = ADDR_WIDTH - IDX - OFF;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_MISS_REQ = 3'd2;
    localparam logic [2:0] ST_REFILL   = 3'd3;
    localparam logic [2:0] ST_RESPOND  = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TAG-1:0]        tag_q;
    logic [IDX-1:0]        idx_q;
    logic [OFF-1:0]        off_q;
    logic [OFF-1:0]        cnt;
    logic                  flush_pending;

    logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][WORDS_PER_BLOCK];
    logic [TAG-1:0]        tag_mem  [WAYS][SETS];
    logic [SETS-1:0]       valid    [WAYS];
    logic [WAY_W-1:0]      rr_ptr   [SETS];

    logic [WAY_W-1:0]      victim_q;
    logic [WAY_W-1:0]      victim_c;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      ptr_next;
    logic                  hit;
    logic                  found_invalid;
    logic                  beat_we;
    logic                  last_beat;

    assign tag_q = addr_q[ADDR_WIDTH-1 -: TAG];
    assign idx_q = addr_q[OFF +: IDX];
    assign off_q = addr_q[OFF-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[w][idx_q] && (tag_mem[w][idx_q] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; the round-robin pointer only decides a full set.
    always_comb begin
        victim_c      = rr_ptr[idx_q];
        found_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid[w][idx_q] && !found_invalid) begin
                victim_c      = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
    end

    assign ptr_next  = (rr_ptr[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx_q] + 1'b1;
    assign beat_we   = (state == ST_REFILL) && mem_resp_valid;
    assign last_beat = beat_we && (cnt == OFF'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            victim_q      <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int unsigned s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            if ((state != ST_IDLE) && flush) flush_pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (flush || flush_pending) begin
                        for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
                        flush_pending <= 1'b0;
                    end else if (req_valid) begin
                        addr_q <= req_addr;
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        state <= ST_IDLE;
                    end else begin
                        victim_q <= victim_c;
                        state    <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (beat_we) cnt <= cnt + 1'b1;
                    if (last_beat) begin
                        valid[victim_q][idx_q] <= 1'b1;
                        rr_ptr[idx_q]          <= ptr_next;
                        state                  <= ST_RESPOND;
                    end
                end
                ST_RESPOND: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) data_mem[victim_q][idx_q][cnt] <= mem_resp_data;
        if (last_beat) tag_mem[victim_q][idx_q] <= tag_q;
    end

    always_comb begin
        req_ready     = !reset && (state == ST_IDLE) && !flush && !flush_pending;
        resp_valid    = 1'b0;
        resp_data     = '0;
        mem_req_valid = (state == ST_MISS_REQ);
        mem_req_addr  = '0;
        busy          = (state == ST_MISS_REQ) || (state == ST_REFILL) || (state == ST_RESPOND);
        if ((state == ST_LOOKUP) && hit) begin
            resp_valid = 1'b1;
            resp_data  = data_mem[hit_way][idx_q][off_q];
        end else if (state == ST_RESPOND) begin
            resp_valid = 1'b1;
            resp_data  = data_mem[victim_q][idx_q][off_q];
        end
        if (state == ST_MISS_REQ) mem_req_addr = {tag_q, idx_q, {OFF{1'b0}}};
    end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed and model-checked bench for set_assoc_icache at default parameters
// (2 ways, 4 sets, 16-word lines).
module tb_set_assoc_icache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush = 1'b0;
    logic        busy;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;

    set_assoc_icache #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WAYS(2), .SETS(4), .WORDS_PER_BLOCK(16)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .flush(flush), .busy(busy), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int          asserts = 0;
    int          errors = 0;
    logic        r_hit;
    logic [31:0] r_data;
    logic [31:0] r_maddr;
    int          r_lat;
    logic        r_stable;
    logic        r_busy_ok;
    int          flush_at_beat = -1;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Issues one fetch and, on a miss, plays the memory side: stall cycles before
    // accepting the fill request and gap cycles between beats. Called and returns on a negedge.
    task automatic do_read(input logic [31:0] a, input int stall, input int gap, input logic [31:0] base);
        int n;
        r_hit = 1'b0; r_data = '0; r_maddr = '0; r_lat = 0; r_stable = 1'b1; r_busy_ok = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            asserts++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid = 1'b1; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0; r_lat = 1;
        if (resp_valid) begin r_hit = 1'b1; r_data = resp_data; return; end
        n = 0;
        while (!mem_req_valid && n < 10) begin @(negedge clk); r_lat++; n++; end
        if (!mem_req_valid) begin
            asserts++; errors++;
            $display("FAIL mem_req_timeout: got 0 expected 1");
            return;
        end
        r_maddr = mem_req_addr;
        for (int s = 0; s < stall; s++) begin
            if (!busy) r_busy_ok = 1'b0;
            @(negedge clk); r_lat++;
            if (!mem_req_valid || mem_req_addr !== r_maddr) r_stable = 1'b0;
        end
        if (!busy) r_busy_ok = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk); r_lat++;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            if (b > 0) repeat (gap) begin
                if (!busy) r_busy_ok = 1'b0;
                @(negedge clk); r_lat++;
            end
            if (!busy) r_busy_ok = 1'b0;
            mem_resp_valid = 1'b1; mem_resp_data = base + b; flush = (b == flush_at_beat);
            @(negedge clk); r_lat++;
            mem_resp_valid = 1'b0; flush = 1'b0;
        end
        n = 0;
        while (!resp_valid && n < 5) begin @(negedge clk); r_lat++; n++; end
        if (!resp_valid) begin
            asserts++; errors++;
            $display("FAIL resp_timeout: got 0 expected 1");
            return;
        end
        if (!busy) r_busy_ok = 1'b0;
        r_data = resp_data;
    endtask

    task automatic test_reset();
        @(negedge clk);
        asserts++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b expected 0", req_ready); end
        asserts++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b expected 0", resp_valid); end
        asserts++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got %h expected 0", resp_data); end
        asserts++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %0b expected 0", mem_req_valid); end
        asserts++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_req_addr: got %h expected 0", mem_req_addr); end
        asserts++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        reset = 1'b0;
        #1;
        asserts++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready: got %0b expected 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_miss_hit();
        do_read(32'h25, 0, 0, 32'h100);
        asserts++; if (r_hit !== 1'b0) begin errors++; $display("FAIL first_miss: got hit %0b expected 0", r_hit); end
        asserts++; if (r_maddr !== 32'h20) begin errors++; $display("FAIL miss_addr: got %h expected 20", r_maddr); end
        asserts++; if (r_lat !== 19) begin errors++; $display("FAIL miss_latency: got %0d expected 19", r_lat); end
        asserts++; if (r_data !== 32'h105) begin errors++; $display("FAIL miss_data: got %h expected 105", r_data); end
        asserts++; if (r_busy_ok !== 1'b1) begin errors++; $display("FAIL miss_busy: got %0b expected 1", r_busy_ok); end
        do_read(32'h25, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1) begin errors++; $display("FAIL rehit: got hit %0b expected 1", r_hit); end
        asserts++; if (r_lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", r_lat); end
        asserts++; if (r_data !== 32'h105) begin errors++; $display("FAIL hit_data: got %h expected 105", r_data); end
        @(negedge clk);
        asserts++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hit_throughput: got %0b expected 1", req_ready); end
        do_read(32'h2F, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1 || r_data !== 32'h10F) begin errors++; $display("FAIL hit_last_word: got %0b/%h expected 1/10f", r_hit, r_data); end
        do_read(32'h20, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1 || r_data !== 32'h100) begin errors++; $display("FAIL hit_first_word: got %0b/%h expected 1/100", r_hit, r_data); end
    endtask

    task automatic test_conflict();
        apply_reset();
        do_read(32'h000, 0, 0, 32'h200);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h200) begin errors++; $display("FAIL fill_way0: got %0b/%h expected 0/200", r_hit, r_data); end
        do_read(32'h040, 0, 0, 32'h300);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h300) begin errors++; $display("FAIL fill_way1: got %0b/%h expected 0/300", r_hit, r_data); end
        do_read(32'h080, 0, 0, 32'h400);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h400) begin errors++; $display("FAIL evict_fill: got %0b/%h expected 0/400", r_hit, r_data); end
        do_read(32'h041, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1 || r_data !== 32'h301) begin errors++; $display("FAIL survivor_hit: got %0b/%h expected 1/301", r_hit, r_data); end
        do_read(32'h000, 0, 0, 32'h200);
        asserts++; if (r_hit !== 1'b0) begin errors++; $display("FAIL evicted_miss: got hit %0b expected 0", r_hit); end
        // Pointer was 1 after the 0x080 fill, so refilling 0x000 must have displaced 0x040.
        do_read(32'h085, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1 || r_data !== 32'h405) begin errors++; $display("FAIL ptr_keeps_way0: got %0b/%h expected 1/405", r_hit, r_data); end
        do_read(32'h040, 0, 0, 32'h300);
        asserts++; if (r_hit !== 1'b0) begin errors++; $display("FAIL ptr_evicts_way1: got hit %0b expected 0", r_hit); end
    endtask

    task automatic test_stall();
        apply_reset();
        do_read(32'h13A, 5, 3, 32'h500);
        asserts++; if (r_hit !== 1'b0 || r_maddr !== 32'h130) begin errors++; $display("FAIL stall_req: got %0b/%h expected 0/130", r_hit, r_maddr); end
        asserts++; if (r_stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got %0b expected 1", r_stable); end
        asserts++; if (r_busy_ok !== 1'b1) begin errors++; $display("FAIL stall_busy: got %0b expected 1", r_busy_ok); end
        asserts++; if (r_data !== 32'h50A) begin errors++; $display("FAIL stall_data: got %h expected 50a", r_data); end
        do_read(32'h134, 0, 0, 32'hDEAD0000);
        asserts++; if (r_hit !== 1'b1 || r_data !== 32'h504) begin errors++; $display("FAIL stall_line_hit: got %0b/%h expected 1/504", r_hit, r_data); end
    endtask

    task automatic test_flush_mid();
        flush_at_beat = 4;
        do_read(32'h25, 0, 0, 32'h100);
        flush_at_beat = -1;
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h105) begin errors++; $display("FAIL flush_mid_resp: got %0b/%h expected 0/105", r_hit, r_data); end
        @(negedge clk);
        asserts++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_pending_ready: got %0b expected 0", req_ready); end
        @(negedge clk);
        asserts++; if (req_ready !== 1'b1) begin errors++; $display("FAIL after_flush_ready: got %0b expected 1", req_ready); end
        do_read(32'h134, 0, 0, 32'h500);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h504) begin errors++; $display("FAIL flushed_old_line: got %0b/%h expected 0/504", r_hit, r_data); end
        do_read(32'h25, 0, 0, 32'h100);
        asserts++; if (r_hit !== 1'b0) begin errors++; $display("FAIL flushed_new_line: got hit %0b expected 0", r_hit); end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h134;
        #1;
        asserts++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_req: got %0b expected 0", req_ready); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        asserts++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_wins: got %0b/%0b expected 0/0", resp_valid, busy); end
        do_read(32'h134, 0, 0, 32'h500);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h504) begin errors++; $display("FAIL flush_idle_miss: got %0b/%h expected 0/504", r_hit, r_data); end
    endtask

    task automatic test_reset_mid();
        logic quiet;
        apply_reset();
        req_valid = 1'b1; req_addr = 32'h25;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h600 + b;
            @(negedge clk);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h607; reset = 1'b1;
        #1;
        asserts++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_mem: got %0b/%0b/%h expected 0/0/0", busy, mem_req_valid, mem_req_addr); end
        asserts++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL rst_mid_resp: got %0b/%0b/%h expected 0/0/0", req_ready, resp_valid, resp_data); end
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int b = 8; b < 16; b++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h600 + b;
            @(negedge clk);
            if (resp_valid || busy) quiet = 1'b0;
        end
        mem_resp_valid = 1'b0;
        asserts++; if (quiet !== 1'b1) begin errors++; $display("FAIL stray_beats: got %0b expected 1", quiet); end
        do_read(32'h25, 0, 0, 32'h700);
        asserts++; if (r_hit !== 1'b0 || r_data !== 32'h705) begin errors++; $display("FAIL rst_mid_refill: got %0b/%h expected 0/705", r_hit, r_data); end
    endtask

    task automatic test_random();
        logic [31:0] mtag [2][4];
        logic        mval [2][4];
        int          mptr [4];
        int          dut_hits, model_hits, v;
        logic        exp_hit;
        logic [31:0] a;
        int unsigned t, i, o;
        apply_reset();
        for (int w = 0; w < 2; w++) for (int s = 0; s < 4; s++) begin mval[w][s] = 1'b0; mtag[w][s] = '0; end
        for (int s = 0; s < 4; s++) mptr[s] = 0;
        dut_hits = 0; model_hits = 0;
        for (int k = 0; k < 40; k++) begin
            t = $urandom_range(0, 2); i = $urandom_range(0, 3); o = $urandom_range(0, 15);
            a = 32'((t << 6) | (i << 4) | o);
            exp_hit = 1'b0;
            for (int w = 0; w < 2; w++) if (mval[w][i] && mtag[w][i] == 32'(t)) exp_hit = 1'b1;
            if (!exp_hit) begin
                v = mval[0][i] ? (mval[1][i] ? mptr[i] : 1) : 0;
                mval[v][i] = 1'b1; mtag[v][i] = 32'(t);
                mptr[i] = (mptr[i] + 1) % 2;
            end else model_hits++;
            do_read(a, k % 3, k % 2, 32'h1000_0000 + (a & 32'hFFFF_FFF0));
            if (r_hit) dut_hits++;
            asserts++; if (r_hit !== exp_hit) begin errors++; $display("FAIL rand_hit[%0d] addr %h: got %0b expected %0b", k, a, r_hit, exp_hit); end
            asserts++; if (r_data !== 32'h1000_0000 + a) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", k, r_data, 32'h1000_0000 + a); end
        end
        asserts++; if (dut_hits !== model_hits) begin errors++; $display("FAIL rand_hit_count: got %0d expected %0d", dut_hits, model_hits); end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_conflict();
        test_stall();
        test_flush_mid();
        test_flush_idle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
